// File: rtl/iddmm_task_responder.sv
// rtl/iddmm_task_responder.sv - word-serial CIOS Montgomery multiplier behind the IDDMM task handshake
module iddmm_task_responder #(
    parameter int K = 256,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           wr_ena,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [K-1:0]         wr_x,
    input  logic [K-1:0]         wr_y,
    input  logic [K-1:0]         wr_m,
    input  logic [K-1:0]         wr_m1,
    input  logic                 task_req,
    output logic                 task_grant,
    output logic                 task_end,
    output logic [K-1:0]         task_res
);

    localparam int CW = $clog2(N);
    localparam int TW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, GRANT, MUL, QCALC, RED, SUB, OUT} state_t;

    state_t          state;
    logic [K-1:0]    x_bank [N];
    logic [K-1:0]    y_bank [N];
    logic [K-1:0]    m_bank [N];
    logic [K-1:0]    m1_reg;
    logic [K-1:0]    t [N+2];
    logic [K-1:0]    d [N];
    logic [K-1:0]    q;
    logic [K-1:0]    carry;
    logic            borrow;
    logic            sel_t;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;

    logic [CW-1:0]   j_prev;
    logic [CW-1:0]   j_next;
    logic [TW-1:0]   tj;
    logic [TW-1:0]   tj_prev;
    logic [K-1:0]    mul_a;
    logic [K-1:0]    mul_b;
    logic [2*K-1:0]  prod;
    logic [K-1:0]    carry_in;
    logic            borrow_in;
    logic [2*K-1:0]  mac;
    logic [K:0]      fold;
    logic [K:0]      diff;
    logic            sel_now;

    // Operands are frozen outside IDLE so a running task sees a stable snapshot.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (wr_ena[0]) x_bank[wr_addr] <= wr_x;
            if (wr_ena[1]) y_bank[wr_addr] <= wr_y;
            if (wr_ena[2]) begin
                m_bank[wr_addr] <= wr_m;
                m1_reg          <= wr_m1;
            end
        end
    end

    // Single shared K x K multiplier, operands steered by state.
    always_comb begin
        j_prev  = j - 1'b1;
        j_next  = j + 1'b1;
        tj      = TW'(j);
        tj_prev = TW'(j_prev);
        mul_a   = x_bank[j];
        mul_b   = y_bank[i];
        case (state)
            QCALC: begin
                mul_a = t[0];
                mul_b = m1_reg;
            end
            RED: begin
                mul_a = m_bank[j];
                mul_b = q;
            end
            default: ;
        endcase
        prod      = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
        carry_in  = (j == '0) ? '0 : carry;
        borrow_in = (j == '0) ? 1'b0 : borrow;
        mac       = prod + {{K{1'b0}}, t[tj]} + {{K{1'b0}}, carry_in};
        fold      = {1'b0, t[N]} + {1'b0, mac[2*K-1:K]};
        diff      = {1'b0, t[tj]} - {1'b0, m_bank[j]} - {{K{1'b0}}, borrow_in};
        sel_now   = (t[N] == '0) && diff[K];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            task_grant <= 1'b0;
            task_end   <= 1'b0;
            task_res   <= '0;
            i          <= '0;
            j          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (task_req) begin
                        task_grant <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    task_grant <= 1'b0;
                    for (int k = 0; k < N + 2; k++) t[k] <= '0;
                    i     <= '0;
                    j     <= '0;
                    state <= MUL;
                end
                MUL: begin
                    t[tj] <= mac[K-1:0];
                    carry <= mac[2*K-1:K];
                    if (j == LAST) begin
                        t[N]   <= fold[K-1:0];
                        t[N+1] <= t[N+1] + K'(fold[K]);
                        j      <= '0;
                        state  <= QCALC;
                    end else begin
                        j <= j_next;
                    end
                end
                QCALC: begin
                    q     <= prod[K-1:0];
                    state <= RED;
                end
                RED: begin
                    // Word 0 of the sum is zero by choice of q; the rest shifts down a word.
                    if (j != '0) t[tj_prev] <= mac[K-1:0];
                    carry <= mac[2*K-1:K];
                    if (j == LAST) begin
                        t[N-1] <= fold[K-1:0];
                        t[N]   <= t[N+1] + K'(fold[K]);
                        t[N+1] <= '0;
                        j      <= '0;
                        i      <= i + 1'b1;
                        state  <= (i == LAST) ? SUB : MUL;
                    end else begin
                        j <= j_next;
                    end
                end
                SUB: begin
                    d[j]   <= diff[K-1:0];
                    borrow <= diff[K];
                    if (j == LAST) begin
                        sel_t    <= sel_now;
                        task_end <= 1'b1;
                        task_res <= sel_now ? t[0] : d[0];
                        j        <= '0;
                        state    <= OUT;
                    end else begin
                        j <= j_next;
                    end
                end
                OUT: begin
                    if (j == LAST) begin
                        task_end <= 1'b0;
                        task_res <= '0;
                        j        <= '0;
                        state    <= IDLE;
                    end else begin
                        task_res <= sel_t ? t[TW'(j_next)] : d[j_next];
                        j        <= j_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iddmm_task_responder.sv
// tb/tb_iddmm_task_responder.sv - directed and random checks of iddmm_task_responder
module tb_iddmm_task_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [2:0]  a_wr_ena;
    logic [0:0]  a_wr_addr;
    logic [7:0]  a_wr_x, a_wr_y, a_wr_m, a_wr_m1;
    logic        a_task_req, a_task_grant, a_task_end;
    logic [7:0]  a_task_res;

    logic [2:0]  b_wr_ena;
    logic [1:0]  b_wr_addr;
    logic [15:0] b_wr_x, b_wr_y, b_wr_m, b_wr_m1;
    logic        b_task_req, b_task_grant, b_task_end;
    logic [15:0] b_task_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iddmm_task_responder #(.K(8), .N(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_ena(a_wr_ena), .wr_addr(a_wr_addr),
        .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_m(a_wr_m), .wr_m1(a_wr_m1),
        .task_req(a_task_req), .task_grant(a_task_grant),
        .task_end(a_task_end), .task_res(a_task_res)
    );

    iddmm_task_responder #(.K(16), .N(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_ena(b_wr_ena), .wr_addr(b_wr_addr),
        .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_m(b_wr_m), .wr_m1(b_wr_m1),
        .task_req(b_task_req), .task_grant(b_task_grant),
        .task_end(b_task_end), .task_res(b_task_res)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic a_write(input logic [2:0] ena, input logic [15:0] x, input logic [15:0] y);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            a_wr_ena  = ena;
            a_wr_addr = 1'(w);
            a_wr_x    = x[w*8 +: 8];
            a_wr_y    = y[w*8 +: 8];
            a_wr_m    = (w == 0) ? 8'hF1 : 8'h00;
            a_wr_m1   = 8'hEF;
        end
        @(negedge clk);
        a_wr_ena = 3'b000;
    endtask

    task automatic a_start();
        int n;
        @(negedge clk);
        a_task_req = 1'b1;
        n = 0;
        while (a_task_grant !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("a_grant_seen", 64'(a_task_grant), 64'd1);
    endtask

    task automatic a_finish(input int exp_lat, input bit keep_req, output logic [15:0] res);
        int lat;
        lat = 0;
        while (a_task_end !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("a_latency", 64'(lat), 64'(exp_lat));
        if (!keep_req) a_task_req = 1'b0;
        res[7:0] = a_task_res;
        @(negedge clk);
        check("a_end_word1", 64'(a_task_end), 64'd1);
        res[15:8] = a_task_res;
        @(negedge clk);
        check("a_end_off", 64'(a_task_end), 64'd0);
    endtask

    task automatic b_write(input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] m, input logic [15:0] m1);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            b_wr_ena  = 3'b111;
            b_wr_addr = 2'(w);
            b_wr_x    = x[w*16 +: 16];
            b_wr_y    = y[w*16 +: 16];
            b_wr_m    = m[w*16 +: 16];
            b_wr_m1   = m1;
        end
        @(negedge clk);
        b_wr_ena = 3'b000;
    endtask

    function automatic logic [15:0] neg_inv16(input logic [15:0] m0);
        logic [15:0] inv;
        inv = m0;
        for (int k = 0; k < 4; k++) inv = inv * (16'd2 - m0 * inv);
        return 16'd0 - inv;
    endfunction

    // Reference: x*y mod m, then divide by 2 modulo m 64 times.
    function automatic logic [63:0] mont_ref(input logic [63:0] x, input logic [63:0] y,
                                             input logic [63:0] m);
        logic [127:0] p;
        logic [64:0]  a;
        p = ({64'd0, x} * {64'd0, y}) % {64'd0, m};
        a = {1'b0, p[63:0]};
        for (int k = 0; k < 64; k++) begin
            if (a[0]) a = a + {1'b0, m};
            a = a >> 1;
        end
        return a[63:0];
    endfunction

    initial begin
        logic [15:0] res;
        logic [63:0] bx, by, bm, bres;
        int cnt;
        int lat;

        vecs[0] = '{16'h00E1, 16'h0005, 16'h0005};
        vecs[1] = '{16'h00E1, 16'h00E1, 16'h00E1};
        vecs[2] = '{16'h0000, 16'h00A7, 16'h0000};
        vecs[3] = '{16'h0001, 16'h00E1, 16'h0001};
        vecs[4] = '{16'h00E1, 16'h00F0, 16'h00F0};
        vecs[5] = '{16'h00A7, 16'h0000, 16'h0000};
        vecs[6] = '{16'h00E1, 16'h00A7, 16'h00A7};

        rst_n = 1'b0;
        a_wr_ena = 3'b000; a_wr_addr = '0; a_wr_x = '0; a_wr_y = '0; a_wr_m = '0; a_wr_m1 = '0;
        a_task_req = 1'b0;
        b_wr_ena = 3'b000; b_wr_addr = '0; b_wr_x = '0; b_wr_y = '0; b_wr_m = '0; b_wr_m1 = '0;
        b_task_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_grant", 64'(a_task_grant), 64'd0);
        check("rst_a_end", 64'(a_task_end), 64'd0);
        check("rst_a_res", 64'(a_task_res), 64'd0);
        check("rst_b_end", 64'(b_task_end), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            a_write(3'b111, vecs[v].x, vecs[v].y);
            a_start();
            a_finish(13, 1'b0, res);
            check($sformatf("a_vec%0d_res", v), 64'(res), 64'(vecs[v].res));
        end

        // x rewritten after grant must not affect the running or the next task.
        a_write(3'b111, 16'h00E1, 16'h0005);
        a_start();
        a_write(3'b001, 16'h0000, 16'h0000);
        a_finish(10, 1'b0, res);
        check("a_frozen_res", 64'(res), 64'h0005);
        a_start();
        a_finish(13, 1'b0, res);
        check("a_frozen_next", 64'(res), 64'h0005);

        // Reset in RED aborts the task; operands survive.
        a_start();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        a_task_req = 1'b0;
        @(negedge clk);
        check("abort_grant", 64'(a_task_grant), 64'd0);
        check("abort_end", 64'(a_task_end), 64'd0);
        check("abort_res", 64'(a_task_res), 64'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (a_task_end === 1'b1 || a_task_grant === 1'b1) cnt++;
        end
        check("abort_quiet", 64'(cnt), 64'd0);
        a_start();
        a_finish(13, 1'b0, res);
        check("abort_retry_res", 64'(res), 64'h0005);

        // Request raised in OUT and dropped before the next clock in IDLE is lost.
        a_start();
        lat = 0;
        while (a_task_end !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("drop_latency", 64'(lat), 64'd13);
        a_task_req = 1'b0;
        @(negedge clk);
        a_task_req = 1'b1;
        @(negedge clk);
        a_task_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_task_grant === 1'b1) cnt++;
        end
        check("drop_no_grant", 64'(cnt), 64'd0);

        // Back-to-back with req held: IDLE cycle, then the next grant.
        a_write(3'b111, 16'h00E1, 16'h00E1);
        a_start();
        a_finish(13, 1'b1, res);
        check("b2b_first_res", 64'(res), 64'h00E1);
        cnt = 1;
        while (a_task_grant !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_gap", 64'(cnt), 64'd2);
        a_finish(13, 1'b0, res);
        check("b2b_second_res", 64'(res), 64'h00E1);

        for (int v = 0; v < 500; v++) begin
            bm = {$urandom, $urandom} | 64'd1;
            if (bm < 64'd3) bm = 64'd3;
            bx = {$urandom, $urandom} % bm;
            by = {$urandom, $urandom} % bm;
            if (v == 0) bx = 64'd0;
            if (v == 1) begin
                bx = bm - 64'd1;
                by = bm - 64'd1;
            end
            if (v == 2) by = 64'd1;
            b_write(bx, by, bm, neg_inv16(bm[15:0]));
            @(negedge clk);
            b_task_req = 1'b1;
            cnt = 0;
            while (b_task_grant !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            lat = 0;
            while (b_task_end !== 1'b1 && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            b_task_req = 1'b0;
            if (v < 3) check("b_latency", 64'(lat), 64'd41);
            bres = '0;
            for (int w = 0; w < 4; w++) begin
                if (b_task_end !== 1'b1) bres = {64{1'bx}};
                else bres[w*16 +: 16] = b_task_res;
                @(negedge clk);
            end
            check($sformatf("b_rand%0d", v), bres, mont_ref(bx, by, bm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iddmm_task_responder.md
Name: iddmm_task_responder

Overview:
- Responder/compute end of the IDDMM task interface driven by the ME and MM clients.
- Accepts operand words (x, y, modulus m, m1 = -m^-1 mod 2^K) over the wr_* write port into N-word banks.
- Arbitrates task_req with a grant pulse and runs word-serial CIOS Montgomery multiplication: res = x*y*R^-1 mod m, where R = 2^(K*N).
- Streams the N result words back, low word first, on task_res/task_end.

Parameters:
- K, 256, bits per word; one K x K multiplier is instantiated.
- N, 16, words per operand; N >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_ena  in  3  bit0 writes x, bit1 writes y, bit2 writes m; wr_m1 is captured whenever bit2 is high.
- wr_addr  in  $clog2(N)  word index, 0 = least significant word.
- wr_x  in  K  x word.
- wr_y  in  K  y word.
- wr_m  in  K  m word.
- wr_m1  in  K  -m^-1 mod 2^K.
- task_req  in  1  level; held by the client until its first task_end cycle.
- task_grant  out  1  one-cycle pulse; operands are frozen from this cycle on.
- task_end  out  1  high for exactly N consecutive cycles; each high cycle qualifies one task_res word.
- task_res  out  K  result word, low word first, valid only while task_end = 1.

Behaviour:
- Reset (rst_n = 0 at a clk edge): task_grant = 0, task_end = 0, task_res = 0, FSM = IDLE.
  - Operand banks are not cleared.
  - Reset asserted mid-task aborts the task; no task_end pulse is produced.
- Writes:
  - Accepted only in IDLE; the written word is readable from the next cycle.
  - wr_ena bits are independent; several bits may be high in the same cycle.
  - Writes in any other state are ignored (this includes the GRANT cycle).
- FSM states: IDLE, GRANT, MUL, QCALC, RED, SUB, OUT.
  - IDLE -> GRANT when task_req = 1.
  - GRANT: task_grant = 1 for 1 cycle; clear accumulator t (N+2 words); i = 0.
  - MUL: j = 0..N-1, one cycle per j.
    - (C, t[j]) = t[j] + x[j]*y[i] + C.
    - After the last j: t[N] += C, and the overflow goes to t[N+1].
  - QCALC (1 cycle): q = (t[0]*m1) mod 2^K.
  - RED: j = 0..N-1, one cycle per j.
    - (C, t') = t[j] + q*m[j] + C.
    - t' for j = 0 is discarded (it is 0 by construction). For j >= 1, t' is written to t[j-1] (shift down one word).
    - After the last j: t[N-1] = t[N] + C with carry into t[N]; t[N] = t[N+1] + that carry; t[N+1] = 0.
    - Then i++. Go to MUL if i < N, otherwise SUB.
  - SUB: N cycles.
    - d[j] = t[j] - m[j] - borrow, low word first.
    - At the end, select t if (t[N] == 0 and the final borrow == 1), otherwise select d.
  - OUT: N cycles.
    - task_end = 1 and task_res = selected word j, for j = 0..N-1.
    - Then IDLE; the next task can be granted no earlier than the following cycle.
- Latency:
  - GRANT cycle to first task_end cycle = N*(2N+1) + N + 1 cycles.
  - Total busy time = 1 + N*(2N+1) + 2N cycles.
- Width and range rules:
  - Inputs must satisfy x, y < m and m odd; otherwise the result is undefined but still exactly N words.
  - Each MAC uses a 2K-bit product plus K-bit addends; carry C is K bits (no overflow possible).
  - Result is always < m.
- Boundary cases:
  - task_req deasserted before grant: the request is dropped; no task runs.
  - task_req held high through OUT: a new task starts after IDLE. Clients must drop req on task_end.
  - x = 0 or y = 0: result is all-zero words.

Test Plan (K = 8, N = 2, R = 2^16, m = 0x00F1, m1 = 0xEF):
- Write x = 0x00E1 (R mod m), y = 0x0005, then task_req -> grant pulse.
  - task_end high for 2 cycles with task_res = 0x05, 0x00, low word first.
  - First task_end cycle exactly 13 cycles after the grant cycle.
- x = 0x00E1, y = 0x00E1 -> result words 0xE1, 0x00 (exercises the final-subtraction select path).
- x = 0, y = 0x00A7 -> result words 0x00, 0x00.
- wr_x written during a running task (after grant) -> ignored; result is identical to the pre-grant operands.
- rst_n pulsed low during the RED state:
  - Outputs go to 0 the next cycle; no task_end appears.
  - A fresh task_req then produces a correct result from the retained operands.
- Back-to-back tasks with task_req held:
  - Second grant occurs >= 1 cycle after the last task_end.
  - 500 random K = 16, N = 4 vectors match a reference model of x*y*R^-1 mod m.
